// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmit arbiter: FSM state
//                encoding and the default byte width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int DEFAULT_DATA_W = 8;

   // Arbiter FSM: offer a byte, pulse start, then track the transmitter's
   // ready flag falling and rising again before offering the next byte.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_LOW  = 2'd2,
      ST_WAIT_HIGH = 2'd3
   } arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. Returns the first set
//                request at or above ptr_i, wrapping from N-1 back to 0, as
//                a one-hot grant plus its index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // Scan offsets from farthest to nearest so the nearest request wins last.
   always_comb begin : p_pick
      int               j;
      logic [IDX_W-1:0] sel;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      j       = 0;
      sel     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= N) begin
            j = j - N;
         end
         sel = IDX_W'(j);
         if (req_i[sel]) begin
            grant_o      = '0;
            grant_o[sel] = 1'b1;
            idx_o        = sel;
            any_o        = 1'b1;
         end
      end
   end

endmodule : rr_picker
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter feeding bytes from NUM_REQ requesters
//                into one shared UART transmitter. Optional packet locking
//                is enabled by defining UART_ARB_PKT_LOCK_EN, which adds the
//                req_last input and holds the grant until a packet's last
//                byte has been accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = DEFAULT_DATA_W,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_PKT_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_last,
`endif
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_ready,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;

   logic [NUM_REQ-1:0] w_pick_req;
   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_pick_any;
   logic               w_offer;
   logic               w_accept;
   logic [IDX_W-1:0]   w_ptr_next;

`ifdef UART_ARB_PKT_LOCK_EN
   logic               lock_q, lock_d;
   logic [NUM_REQ-1:0] w_lock_mask;

   // While a packet is open only its owner is presented to the picker.
   assign w_lock_mask = NUM_REQ'(1) << grant_id_q;
   assign w_pick_req  = lock_q ? (req_valid & w_lock_mask) : req_valid;
`else
   assign w_pick_req  = req_valid;
`endif

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .req_i   (w_pick_req),
      .ptr_i   (rr_ptr_q),
      .grant_o (w_pick_gnt),
      .idx_o   (w_pick_idx),
      .any_o   (w_pick_any)
   );

   // A byte is offered only while idle and the transmitter reports idle;
   // rst gates the offer so nothing is accepted during reset.
   assign w_offer    = (state_q == ST_IDLE) && tx_ready && !rst;
   assign w_accept   = w_offer && w_pick_any;
   assign req_ready  = w_offer ? w_pick_gnt : '0;
   assign w_ptr_next = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

   assign tx_start   = (state_q == ST_ISSUE);
   assign busy       = (state_q != ST_IDLE);
   assign tx_data    = tx_data_q;
   assign grant_id   = grant_id_q;

   // Next-state, capture of the accepted byte and pointer update.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      tx_data_d  = tx_data_q;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_d     = lock_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d    = ST_ISSUE;
               tx_data_d  = req_data[int'(w_pick_idx)*DATA_W +: DATA_W];
               grant_id_d = w_pick_idx;
`ifdef UART_ARB_PKT_LOCK_EN
               // Pointer only moves once the packet's last byte is taken.
               if (req_last[w_pick_idx]) begin
                  lock_d   = 1'b0;
                  rr_ptr_d = w_ptr_next;
               end else begin
                  lock_d   = 1'b1;
               end
`else
               rr_ptr_d   = w_ptr_next;
`endif
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            // The transmitter may still show ready here; wait for it to drop.
            if (!tx_ready) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (tx_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         tx_data_q  <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         tx_data_q  <= tx_data_d;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 Parameter DATA_W, default 8, byte width.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-007 req_data  input  NUM_REQ*DATA_W  packed bytes; requester i at bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-009 tx_start  output  1  one-cycle start pulse to the shared transmitter.
REQ-010 tx_data  output  DATA_W  byte to transmit; stable from tx_start until the transmitter returns ready.
REQ-011 tx_ready  input  1  transmitter idle flag; drops the cycle after tx_start and rises when the stop bit completes.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester whose byte is in flight.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM shall have states IDLE, ISSUE, WAIT_LOW and WAIT_HIGH.
- IDLE -> ISSUE on acceptance.
- ISSUE -> WAIT_LOW unconditionally.
- WAIT_LOW -> WAIT_HIGH when tx_ready=0.
- WAIT_HIGH -> IDLE when tx_ready=1.
REQ-015 In IDLE with tx_ready=1, req_ready shall combinationally assert only for the round-robin winner: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NUM_REQ-1 -> 0.
REQ-016 req_ready shall be all-zero in every state other than IDLE, and in IDLE when tx_ready=0.
REQ-017 On acceptance, the arbiter shall register req_data of the winner into tx_data, set grant_id to the winner, and set rr_ptr to winner+1 modulo NUM_REQ.
REQ-018 tx_start shall be high for exactly the single cycle spent in ISSUE; latency from the acceptance edge to tx_start is 1 cycle.
REQ-019 WAIT_LOW shall ignore tx_ready=1 for up to 1 cycle, since the transmitter drops ready one cycle after start; a new byte shall never be accepted before tx_ready has been seen low and then high again.
REQ-020 Back-to-back operation: acceptance is permitted in the IDLE cycle immediately after WAIT_HIGH exits.
REQ-021 Simultaneous requests shall be served in round-robin order; with all NUM_REQ valid continuously, each requester shall receive exactly one grant per NUM_REQ bytes.
REQ-022 req_valid deasserted by a non-winning requester shall have no effect on rr_ptr.
REQ-023 tx_data and grant_id shall hold their values until the next acceptance.

Reset
REQ-024 Asserting rst at any time, including mid-byte, shall immediately force:
- state=IDLE, rr_ptr=0, tx_start=0, tx_data=0, grant_id=0, busy=0;
- req_ready low while rst is high.
REQ-025 After reset release, the first acceptance shall honour tx_ready; the arbiter shall not assume the transmitter is idle.

Configuration
REQ-026 Macro UART_ARB_PKT_LOCK_EN, when defined, shall add input req_last (width NUM_REQ), which marks the final byte of a packet.
REQ-027 With UART_ARB_PKT_LOCK_EN defined, after accepting a byte with req_last[grant]=0, the grant shall lock to grant_id:
- only that requester may be accepted next;
- rr_ptr shall not advance until a byte with req_last=1 is accepted.
REQ-028 With UART_ARB_PKT_LOCK_EN undefined, there shall be no req_last port and every byte shall be arbitrated independently.

Structure
REQ-029 A shared package uart_pkg shall hold the FSM state enum/encodings and the default DATA_W.
REQ-030 Round-robin winner selection shall be a separate combinational sub-module, rr_picker (inputs: request vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-031 Single request: req_valid=4'b0010 with byte 0x41, model tx_ready behaviour -> one tx_start pulse one cycle after acceptance, tx_data=0x41, grant_id=1, req_ready[1] high for one cycle.
REQ-032 All-valid contention: req_valid=4'b1111 held for 8 bytes -> grant order 0,1,2,3,0,1,2,3.
REQ-033 Transmitter busy: tx_ready=0 in IDLE with req_valid=4'b0001 -> req_ready stays 0 and no tx_start until tx_ready=1.
REQ-034 Reset mid-byte: assert rst during WAIT_HIGH -> busy=0, tx_start=0, tx_data=0 immediately; after release, the next grant goes to requester 0.
REQ-035 Wrap-around: rr_ptr=3 with req_valid=4'b1001 -> grants 3 then 0.
REQ-036 With UART_ARB_PKT_LOCK_EN: requester 2 sends 3 bytes with last=0,0,1 while requester 0 is valid -> bytes 2,2,2 are sent, then requester 0.
